// File: rtl/simd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simd_sequencer_pkg
// Purpose  : Shared opcode encoding, sequencer FSM state type, counter width
//            and instruction field offset helpers for simd_sequencer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package simd_sequencer_pkg;

  // Control opcodes; every other value is a vector op forwarded to the PEs.
  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_SETMASK = 4'd14,
    OP_HALT    = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_FINISH
  } state_e;

  localparam int unsigned c_REP_WIDTH = 8;
  // Wide enough for the repeat count and for any supported latency.
  localparam int unsigned c_CNT_WIDTH = 8;

  // Instruction layout, LSB first: opcode | a_addr | b_addr | r_addr | rep
  localparam int unsigned c_OPC_LSB = 0;

  function automatic int unsigned f_a_lsb(input int unsigned opw);
    return opw;
  endfunction

  function automatic int unsigned f_b_lsb(input int unsigned opw, input int unsigned aw);
    return opw + aw;
  endfunction

  function automatic int unsigned f_r_lsb(input int unsigned opw, input int unsigned aw);
    return opw + 2 * aw;
  endfunction

  function automatic int unsigned f_rep_lsb(input int unsigned opw, input int unsigned aw);
    return opw + 3 * aw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_counter
// Purpose  : Loadable down-counter with zero flag, used for both the
//            vector repeat count and the fetch/read/exec latency phases.
// Ports    : clk, rst       - clock, sync active-high reset
//            load, load_val - load count (has priority over dec)
//            dec            - decrement by one, saturating at zero
//            zero           - count is zero
// Revision : 1.0 - initial release
// ============================================================================
module seq_counter
  import simd_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = c_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/simd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : simd_sequencer
// Purpose  : Instruction sequencer for an external SIMD PE array. Fetches
//            instructions from an instruction BRAM, drives operand/result
//            BRAM addresses, PE opcode/valid and per-lane write mask.
// Ports    : clk, rst                 - clock, sync active-high reset
//            start, start_pc, abort   - program control
//            busy, done, err          - status
//            pc, ins_rdata            - instruction BRAM read port
//            a_addr, b_addr           - operand BRAM read addresses
//            r_addr, r_wen            - result BRAM write port
//            pe_op, pe_valid          - PE array control
//            lane_mask                - per-lane write enable
// Revision : 1.0 - initial release
// ============================================================================
module simd_sequencer
  import simd_sequencer_pkg::*;
#(
  parameter int unsigned PE_COUNT       = 8,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned INS_ADDR_WIDTH = 8,
  parameter int unsigned INS_WIDTH      = 64,
  parameter int unsigned OPCODE_WIDTH   = 4,
  parameter int unsigned RD_LATENCY     = 2,
  parameter int unsigned PE_LATENCY     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [INS_ADDR_WIDTH-1:0] start_pc,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [INS_ADDR_WIDTH-1:0] pc,
  input  logic [INS_WIDTH-1:0]      ins_rdata,
  output logic [ADDR_WIDTH-1:0]     a_addr,
  output logic [ADDR_WIDTH-1:0]     b_addr,
  output logic [ADDR_WIDTH-1:0]     r_addr,
  output logic                      r_wen,
  output logic [OPCODE_WIDTH-1:0]   pe_op,
  output logic                      pe_valid,
  output logic [PE_COUNT-1:0]       lane_mask
);

  localparam int unsigned c_A_LSB   = f_a_lsb(OPCODE_WIDTH);
  localparam int unsigned c_B_LSB   = f_b_lsb(OPCODE_WIDTH, ADDR_WIDTH);
  localparam int unsigned c_R_LSB   = f_r_lsb(OPCODE_WIDTH, ADDR_WIDTH);
  localparam int unsigned c_REP_LSB = f_rep_lsb(OPCODE_WIDTH, ADDR_WIDTH);
  localparam int unsigned c_INS_TOP = c_REP_LSB + c_REP_WIDTH;

  // Latency phases count down to zero, so FETCH/EXEC load N-1 (N cycles).
  // READ loads RD_LATENCY so it lasts RD_LATENCY+1 cycles, the last of which
  // carries pe_valid once operand data has arrived.
  localparam logic [c_CNT_WIDTH-1:0] c_FETCH_LAT = c_CNT_WIDTH'(RD_LATENCY - 1);
  localparam logic [c_CNT_WIDTH-1:0] c_READ_LAT  = c_CNT_WIDTH'(RD_LATENCY);
  localparam logic [c_CNT_WIDTH-1:0] c_EXEC_LAT  = c_CNT_WIDTH'(PE_LATENCY - 1);

  localparam logic [INS_ADDR_WIDTH-1:0] c_PC_ONE   = {{(INS_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0]     c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                    state_q, state_d;
  logic [INS_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]     a_addr_q, a_addr_d;
  logic [ADDR_WIDTH-1:0]     b_addr_q, b_addr_d;
  logic [ADDR_WIDTH-1:0]     r_addr_q, r_addr_d;
  logic [OPCODE_WIDTH-1:0]   op_q, op_d;
  logic [PE_COUNT-1:0]       mask_q, mask_d;
  logic                      busy_q, busy_d;
  logic                      err_q, err_d;
  logic                      done_q, done_d;

  logic                      lat_load, lat_dec, lat_zero;
  logic [c_CNT_WIDTH-1:0]    lat_val;
  logic                      it_load, it_dec, it_zero;
  logic                      w_advance;
  logic                      w_pc_last;
  logic [OPCODE_WIDTH-1:0]   w_opcode;
  logic                      w_is_nop, w_is_setmask, w_is_halt;
  logic                      w_unused_ins;

  assign w_opcode     = ins_rdata[c_OPC_LSB +: OPCODE_WIDTH];
  assign w_is_nop     = (w_opcode == OPCODE_WIDTH'(OP_NOP));
  assign w_is_setmask = (w_opcode == OPCODE_WIDTH'(OP_SETMASK));
  assign w_is_halt    = (w_opcode == OPCODE_WIDTH'(OP_HALT));
  assign w_pc_last    = (pc_q == {INS_ADDR_WIDTH{1'b1}});
  assign w_unused_ins = ^ins_rdata[INS_WIDTH-1:c_INS_TOP];

  seq_counter #(.WIDTH(c_CNT_WIDTH)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (lat_val),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  seq_counter #(.WIDTH(c_REP_WIDTH)) u_iter_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (it_load),
    .load_val (ins_rdata[c_REP_LSB +: c_REP_WIDTH]),
    .dec      (it_dec),
    .zero     (it_zero)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    a_addr_d  = a_addr_q;
    b_addr_d  = b_addr_q;
    r_addr_d  = r_addr_q;
    op_d      = op_q;
    mask_d    = mask_q;
    busy_d    = busy_q;
    err_d     = err_q;
    done_d    = 1'b0;
    lat_load  = 1'b0;
    lat_val   = c_FETCH_LAT;
    lat_dec   = 1'b0;
    it_load   = 1'b0;
    it_dec    = 1'b0;
    w_advance = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      err_d   = 1'b1;
      // FINISH already emits its own done pulse.
      done_d  = (state_q != S_FINISH);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            pc_d     = start_pc;
            err_d    = 1'b0;
            busy_d   = 1'b1;
            state_d  = S_FETCH;
            lat_load = 1'b1;
            lat_val  = c_FETCH_LAT;
          end
        end
        S_FETCH: begin
          if (lat_zero) begin
            state_d = S_DECODE;
          end else begin
            lat_dec = 1'b1;
          end
        end
        S_DECODE: begin
          // ins_rdata is valid here; its fields are captured on this edge.
          if (w_is_halt) begin
            state_d = S_FINISH;
          end else if (w_is_nop || w_is_setmask) begin
            if (w_is_setmask) begin
              mask_d = ins_rdata[c_A_LSB +: PE_COUNT];
            end
            w_advance = 1'b1;
          end else begin
            op_d     = w_opcode;
            a_addr_d = ins_rdata[c_A_LSB +: ADDR_WIDTH];
            b_addr_d = ins_rdata[c_B_LSB +: ADDR_WIDTH];
            r_addr_d = ins_rdata[c_R_LSB +: ADDR_WIDTH];
            it_load  = 1'b1;
            lat_load = 1'b1;
            lat_val  = c_READ_LAT;
            state_d  = S_READ;
          end
        end
        S_READ: begin
          if (lat_zero) begin
            lat_load = 1'b1;
            lat_val  = c_EXEC_LAT;
            state_d  = S_EXEC;
          end else begin
            lat_dec = 1'b1;
          end
        end
        S_EXEC: begin
          if (lat_zero) begin
            state_d = S_WRITE;
          end else begin
            lat_dec = 1'b1;
          end
        end
        S_WRITE: begin
          if (!it_zero) begin
            it_dec   = 1'b1;
            a_addr_d = a_addr_q + c_ADDR_ONE;
            b_addr_d = b_addr_q + c_ADDR_ONE;
            r_addr_d = r_addr_q + c_ADDR_ONE;
            lat_load = 1'b1;
            lat_val  = c_READ_LAT;
            state_d  = S_READ;
          end else begin
            w_advance = 1'b1;
          end
        end
        S_FINISH: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      // pc never wraps: running off the end of instruction memory is a fault.
      if (w_advance) begin
        if (w_pc_last) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          pc_d     = pc_q + c_PC_ONE;
          lat_load = 1'b1;
          lat_val  = c_FETCH_LAT;
          state_d  = S_FETCH;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      r_addr_q <= '0;
      op_q     <= '0;
      mask_q   <= '1;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      r_addr_q <= r_addr_d;
      op_q     <= op_d;
      mask_q   <= mask_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  // Write and valid strobes are cancelled combinationally so an abort or
  // reset arriving in the same cycle never lets a result reach the BRAM.
  assign r_wen     = (state_q == S_WRITE) && !abort && !rst;
  assign pe_valid  = (state_q == S_READ) && lat_zero && !abort && !rst;
  assign done      = done_q || (state_q == S_FINISH);
  assign busy      = busy_q;
  assign err       = err_q;
  assign pc        = pc_q;
  assign a_addr    = a_addr_q;
  assign b_addr    = b_addr_q;
  assign r_addr    = r_addr_q;
  assign pe_op     = op_q;
  assign lane_mask = mask_q;

endmodule
`default_nettype wire

// File: doc/simd_sequencer.md
SIMD_SEQUENCER -- requirements
Module: simd_sequencer

Interface
REQ-001 SHALL have parameters: PE_COUNT=8 (lanes); ADDR_WIDTH=10 (data BRAM address bits); INS_ADDR_WIDTH=8 (instruction address bits); INS_WIDTH=64; OPCODE_WIDTH=4; RD_LATENCY=2 (BRAM read latency, 1..4); PE_LATENCY=3 (PE array latency, 1..8).
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 Ports (name dir width meaning):
- clk in 1 clock
- rst in 1 sync active-high reset
- start in 1 pulse, begin program at start_pc
- start_pc in INS_ADDR_WIDTH first instruction address
- abort in 1 sync cancel
- busy out 1 program running
- done out 1 one-cycle completion pulse
- err out 1 sticky fault flag, cleared by next accepted start
- pc out INS_ADDR_WIDTH instruction BRAM read address
- ins_rdata in INS_WIDTH instruction BRAM data
- a_addr, b_addr out ADDR_WIDTH each operand BRAM read addresses
- r_addr out ADDR_WIDTH result BRAM write address
- r_wen out 1 result write enable
- pe_op out OPCODE_WIDTH opcode to PE array
- pe_valid out 1 operands valid at PE inputs this cycle
- lane_mask out PE_COUNT per-lane write-enable mask

Function
REQ-004 Instruction fields, LSB first: opcode[OPCODE_WIDTH], a_addr, b_addr, r_addr (ADDR_WIDTH each), rep[8]; remaining bits ignored.
REQ-005 Opcodes: 0 NOP; 1..13 vector ops, forwarded on pe_op; 14 SETMASK, lane_mask <= low PE_COUNT bits of the a_addr field onward; 15 HALT.
REQ-006 FSM states: IDLE, FETCH, DECODE, READ, EXEC, WRITE, FINISH.
REQ-007 IDLE: start=1 -> pc<=start_pc, err<=0, busy<=1, go to FETCH; start while busy SHALL be ignored.
REQ-008 FETCH: hold pc RD_LATENCY cycles, latch ins_rdata, go to DECODE.
REQ-009 DECODE transitions:
- NOP or SETMASK -> advance pc, go to FETCH.
- HALT -> FINISH.
- Vector op: load iteration counter with rep, go to READ.
REQ-010 READ: drive a_addr/b_addr for RD_LATENCY cycles, then assert pe_valid for 1 cycle, go to EXEC.
REQ-011 EXEC: wait PE_LATENCY cycles, go to WRITE.
REQ-012 WRITE: r_wen=1 for exactly 1 cycle at r_addr.
- Counter nonzero: decrement; a/b/r addresses +1 modulo 2^ADDR_WIDTH; go to READ.
- Counter zero: advance pc, go to FETCH.
- Result: a vector op executes rep+1 times.
REQ-013 Cycles per vector iteration SHALL be RD_LATENCY+1+PE_LATENCY+1.
REQ-014 pc advance from 2^INS_ADDR_WIDTH-1 SHALL NOT wrap: set err=1, go to FINISH.
REQ-015 FINISH: done=1 for one cycle, busy<=0, go to IDLE.
REQ-016 lane_mask SHALL persist across programs; it is set only by SETMASK or reset.
REQ-017 abort in any non-IDLE state:
- Next cycle: state IDLE, busy=0, r_wen=0, pe_valid=0, err=1, done pulse.
- A write in the same cycle as abort SHALL be suppressed.
REQ-018 start and abort together in IDLE: abort wins; start is dropped.

Reset
REQ-019 On rst, state SHALL be IDLE and outputs SHALL be:
- busy=0, done=0, err=0, r_wen=0, pe_valid=0
- pc=0, a_addr=b_addr=r_addr=0, pe_op=0
- lane_mask all ones
REQ-020 rst SHALL take precedence over start and abort, including mid-program; no r_wen pulse in the reset cycle.

Structure
REQ-021 Opcode enum (NOP, SETMASK=14, HALT=15), field offsets, and FSM state typedef SHALL live in the shared params package.
REQ-022 The iteration/latency counter SHALL be one sub-module, seq_counter: load, decrement, zero flag.
REQ-023 Data BRAMs and the PE array SHALL remain outside this module.

Verification
REQ-024 Single add (opcode 1, a=0x10, b=0x20, r=0x30, rep=0) at pc 0, then HALT:
- One r_wen at r_addr=0x30.
- done exactly 12 cycles after decode of HALT chain per REQ-013 (defaults), err=0.
REQ-025 rep=3, r=0x3FE: r_wen at 0x3FE, 0x3FF, 0x000, 0x001 (address wrap); four pe_valid pulses, each 7 cycles apart.
REQ-026 SETMASK 0x0F, then op: lane_mask=0x0F during WRITE; unchanged after HALT and next start.
REQ-027 abort asserted in the WRITE cycle of the 2nd of 4 iterations:
- Only one r_wen observed.
- Next cycle: busy=0, err=1, done=1.
REQ-028 Program at start_pc=0xFF with no HALT: err=1, done pulse, pc not wrapped.
REQ-029 rst mid-EXEC: next cycle all outputs at reset values; lane_mask=0xFF; start ignored while rst=1.
